mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Moore-style main controller for the multi-cycle MIPS datapath. It sequences PC, IR, register file, ALU, memory and the immediate extender through a fixed state machine, one micro-step per clock. It decodes opcode/funct into ALU operation and immediate-extension mode: sign-extend for arithmetic, load/store and branch; zero-extend for logical immediates. It sits between the instruction register and every datapath enable/mux select.

Parameters:
RESET_PC_EN, 0, value of pc_en while reset is high (kept 0; exists for bring-up benches only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH and all write enables low
opcode  in  6  IR[31:26], stable from DECODE until next FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in BRANCH cycle
pc_en  out  1  PC load = pc_write | (branch & taken)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  data memory write
ir_write  out  1  IR load
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2
ext_zero  out  1  immediate extender mode: 1 = zero-extend, 0 = sign-extend
alu_control  out  3  ALU op code
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  out  1  one-cycle pulse on unsupported opcode
state_dbg  out  4  current state encoding

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, IEXEC, IWB, BRANCH, JUMP.
- reset asserted (asynchronous): state = FETCH; op_q = 0; all outputs 0 except alu_src_b = 01, alu_control = ADD, state_dbg = FETCH encoding; pc_en = RESET_PC_EN.
- FETCH: iord = 0; ir_write = 1; alu_src_a = 0; alu_src_b = 01; ADD; pc_src = 00; pc_write = 1. Next state: DECODE.
- DECODE: alu_src_a = 0; alu_src_b = 11; ADD; ext_zero = 0 (branch target precompute). Latch opcode into op_q and funct into fn_q.
- DECODE next state:
  - lw / sw (100011 / 101011) -> MEMADR
  - R-type (000000) -> RTEXEC
  - beq / bne (000100 / 000101) -> BRANCH
  - addi / andi / ori (001000 / 001100 / 001101) -> IEXEC
  - j (000010) -> JUMP
  - any other opcode -> FETCH, with illegal = 1 for that one DECODE cycle (instruction treated as nop).
- MEMADR: alu_src_a = 1; alu_src_b = 10; ADD; ext_zero = 0. Next: MEMRD if op_q = lw, else MEMWR.
- MEMRD: iord = 1. Next: MEMWB.
- MEMWB: reg_dst = 0; mem_to_reg = 1; reg_write = 1. Next: FETCH.
- MEMWR: iord = 1; mem_write = 1. Next: FETCH.
- RTEXEC: alu_src_a = 1; alu_src_b = 00; alu_control from fn_q:
  - add -> ADD 010; sub -> SUB 110; and -> AND 000; or -> OR 001; slt -> SLT 111
  - any other funct -> ADD, with illegal = 1 in this cycle.
  Next: RTWB.
- RTWB: reg_dst = 1; mem_to_reg = 0; reg_write = 1. Next: FETCH.
- IEXEC: alu_src_a = 1; alu_src_b = 10.
  - addi: ADD, ext_zero = 0
  - andi: AND, ext_zero = 1
  - ori: OR, ext_zero = 1
  Next: IWB.
- IWB: reg_dst = 0; mem_to_reg = 0; reg_write = 1; alu_control and ext_zero held from IEXEC. Next: FETCH.
- BRANCH: alu_src_a = 1; alu_src_b = 00; SUB; pc_src = 01; branch = 1; taken = zero ^ (op_q == bne). Next: FETCH.
- JUMP: pc_src = 10; pc_write = 1. Next: FETCH.
- CPI: lw 5, sw 4, R 4, I-arith 4, branch 3, jump 3, illegal 2.
- Decode uses op_q/fn_q after DECODE, so IR changes after DECODE have no effect.
- Enable outputs are decoded combinationally from state registers only (glitch-free Moore); the only input-dependent terms are pc_en in BRANCH and illegal in DECODE/RTEXEC.
- Reset mid-instruction aborts it; no partial write occurs after the reset edge.

Decomposition:
- Package mips_ctrl_pkg holds: state encodings, opcode constants, funct constants, ALU op codes (ADD/SUB/AND/OR/SLT), alu_src_b and pc_src select constants.
- One natural sub-module: mips_alu_decoder (combinational fn_q -> alu_control plus illegal_funct).

Test Plan:
- reset high mid-MEMRD, release -> state_dbg = FETCH; next edge ir_write = 1, pc_en = 1; reg_write/mem_write stay 0 throughout.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; mem_to_reg = 1 and reg_write = 1 only in cycle 5.
- ori (001101) -> IEXEC shows ext_zero = 1, alu_control = 001; addi (001000) shows ext_zero = 0, alu_control = 010.
- beq with zero = 1 -> pc_en = 1 in BRANCH; bne with zero = 1 -> pc_en = 0; bne with zero = 0 -> pc_en = 1.
- R-type funct 101010 -> alu_control = 111, RTWB reg_dst = 1; funct 000000 -> illegal pulses 1 cycle in RTEXEC, alu_control = 010.
- opcode 111111 -> illegal = 1 in DECODE only, next state FETCH, no write enable asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct decoder: maps the latched funct field to an ALU operation and
// flags funct codes the datapath does not implement.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_illegal_funct
);

    always_comb begin
        o_alu_control   = ALU_ADD;
        o_illegal_funct = 1'b0;
        case (i_funct)
            FN_ADD:  o_alu_control = ALU_ADD;
            FN_SUB:  o_alu_control = ALU_SUB;
            FN_AND:  o_alu_control = ALU_AND;
            FN_OR:   o_alu_control = ALU_OR;
            FN_SLT:  o_alu_control = ALU_SLT;
            default: o_illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main controller for the multi-cycle MIPS datapath: one micro-step per
// clock, enables decoded from the state register and the latched opcode/funct.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit RESET_PC_EN = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    output logic       o_pc_en,
    output logic       o_iord,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_ext_zero,
    output logic [2:0] o_alu_control,
    output logic [1:0] o_pc_src,
    output logic       o_illegal,
    output logic [3:0] o_state_dbg
);

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_op_q;
    logic [5:0] r_fn_q;
    logic [2:0] w_rt_alu;
    logic       w_rt_illegal;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_taken;

    mips_alu_decoder u_alu_decoder (
        .i_funct         (r_fn_q),
        .o_alu_control   (w_rt_alu),
        .o_illegal_funct (w_rt_illegal)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_FETCH;
            r_op_q  <= 6'd0;
            r_fn_q  <= 6'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_op_q <= i_opcode;
                r_fn_q <= i_funct;
            end
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW:             w_next_state = S_MEMADR;
                    OP_RTYPE:                 w_next_state = S_RTEXEC;
                    OP_BEQ, OP_BNE:           w_next_state = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next_state = S_IEXEC;
                    OP_J:                     w_next_state = S_JUMP;
                    default:                  w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_RTEXEC: w_next_state = S_RTWB;
            S_IEXEC:  w_next_state = S_IWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Only pc_en (BRANCH) and illegal (DECODE/RTEXEC) look at inputs.
    assign w_taken = i_zero ^ (r_op_q == OP_BNE);

    always_comb begin
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        o_iord        = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = SRCB_B;
        o_ext_zero    = 1'b0;
        o_alu_control = ALU_ADD;
        o_pc_src      = PCSRC_ALU;
        o_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_ir_write  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                w_pc_write  = 1'b1;
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH;
                case (i_opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_J: o_illegal = 1'b0;
                    default:                        o_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: o_iord = 1'b1;
            S_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            S_RTEXEC: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = w_rt_alu;
                o_illegal     = w_rt_illegal;
            end
            S_RTWB: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
            end
            S_IEXEC, S_IWB: begin
                if (r_state == S_IEXEC) begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = SRCB_IMM;
                end else begin
                    o_reg_write = 1'b1;
                end
                case (r_op_q)
                    OP_ANDI: begin
                        o_alu_control = ALU_AND;
                        o_ext_zero    = 1'b1;
                    end
                    OP_ORI: begin
                        o_alu_control = ALU_OR;
                        o_ext_zero    = 1'b1;
                    end
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            S_BRANCH: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = ALU_SUB;
                o_pc_src      = PCSRC_ALUOUT;
                w_branch      = 1'b1;
            end
            S_JUMP: begin
                o_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase

        o_pc_en = w_pc_write | (w_branch & w_taken);

        // Reset masks every enable immediately, before the state register settles.
        if (i_reset) begin
            o_pc_en       = RESET_PC_EN;
            o_iord        = 1'b0;
            o_mem_write   = 1'b0;
            o_ir_write    = 1'b0;
            o_reg_dst     = 1'b0;
            o_mem_to_reg  = 1'b0;
            o_reg_write   = 1'b0;
            o_alu_src_a   = 1'b0;
            o_alu_src_b   = SRCB_FOUR;
            o_ext_zero    = 1'b0;
            o_alu_control = ALU_ADD;
            o_pc_src      = PCSRC_ALU;
            o_illegal     = 1'b0;
        end
    end

    assign o_state_dbg = r_state;

endmodule
